// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: combinational freeze/bubble/flush
// decode, a MEM_WAIT watchdog FSM and saturating stall/flush performance counters.
//
//   state    | meaning
//   RUN      | no outstanding multi-cycle memory access
//   MEM_WAIT | memory access waiting on mem_ready, wait_cnt_q counts not-ready cycles
//   ERROR    | watchdog expired; back end held frozen until reset
module pipeline_stall_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_counters,
  output logic             freeze_front,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             freeze_back,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [15:0]      TMO     = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic [15:0]      wait_cnt_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             mem_stall;

  // Priority: memory stall > branch flush > hazard stall. A branch under a memory
  // stall stays in EXE (EXE/MEM frozen), so the flush is deferred, not dropped.
  always_comb begin
    mem_stall     = (mem_req & ~mem_ready) | (state_q == ERROR);
    freeze_back   = mem_stall;
    freeze_front  = mem_stall | (hazard_detected & ~branch_taken);
    flush_if_id   = branch_taken & ~mem_stall;
    bubble_id_exe = (hazard_detected | branch_taken) & ~mem_stall;
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (clr_counters) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (freeze_front && stall_q != CNT_MAX) stall_d = stall_q + CNT_W'(1);
      if (flush_if_id && flush_q != CNT_MAX)  flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 16'd1;
          end
        end
        MEM_WAIT: begin
          // A dropped mem_req is a protocol violation; treat it like completion.
          if (mem_ready || !mem_req) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == TMO) begin
            state_q       <= ERROR;
            timeout_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        ERROR: begin
          timeout_err_q <= 1'b1;
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign timeout_err  = timeout_err_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule
